// File: rtl/factor_seq_n.sv
// Sequential 2/3/5[/7] prime-power factoriser with ready/valid in and out.
// Define FACTOR_P7_EN to add the DIV7 stage and count factors of 7.
module factor_seq_n #(
    parameter int WIDTH = 16,
    parameter int P2_W  = 4,
    parameter int P3_W  = 4,
    parameter int P5_W  = 3,
    parameter int P7_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_ready,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [P2_W-1:0]  o_p2,
    output logic [P3_W-1:0]  o_p3,
    output logic [P5_W-1:0]  o_p5,
    output logic [P7_W-1:0]  o_p7,
    output logic [WIDTH-1:0] o_rem,
    output logic [50:0]      number
);

`ifdef FACTOR_P7_EN
    typedef enum logic [2:0] {
        IDLE, DIV2, DIV3, DIV5, DIV7, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, DIV2, DIV3, DIV5, DONE
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [P2_W-1:0]  c2_q, c2_d;
    logic [P3_W-1:0]  c3_q, c3_d;
    logic [P5_W-1:0]  c5_q, c5_d;
    logic             accept;
    logic             r_nz;

    // Constant dividers: synthesis maps these to multiply/shift networks.
    logic [WIDTH-1:0] q3, m3, q5, m5;
    assign q3 = r_q / WIDTH'(3);
    assign m3 = r_q % WIDTH'(3);
    assign q5 = r_q / WIDTH'(5);
    assign m5 = r_q % WIDTH'(5);

    assign r_nz    = (r_q != '0);
    assign o_ready = (state_q == IDLE) |
                     ((state_q == DONE) & i_out_ready);
    assign accept  = i_in_valid & o_ready;

`ifdef FACTOR_P7_EN
    logic [P7_W-1:0]  c7_q, c7_d;
    logic [WIDTH-1:0] q7, m7;
    assign q7 = r_q / WIDTH'(7);
    assign m7 = r_q % WIDTH'(7);
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        c5_d    = c5_q;
`ifdef FACTOR_P7_EN
        c7_d    = c7_q;
`endif
        unique case (state_q)
            IDLE: ;
            DIV2: begin
                if (r_nz && !r_q[0]) begin
                    r_d  = r_q >> 1;
                    c2_d = (&c2_q) ? c2_q : c2_q + 1'b1;
                end else begin
                    state_d = DIV3;
                end
            end
            DIV3: begin
                if (r_nz && m3 == '0) begin
                    r_d  = q3;
                    c3_d = (&c3_q) ? c3_q : c3_q + 1'b1;
                end else begin
                    state_d = DIV5;
                end
            end
            DIV5: begin
                if (r_nz && m5 == '0) begin
                    r_d  = q5;
                    c5_d = (&c5_q) ? c5_q : c5_q + 1'b1;
                end else begin
`ifdef FACTOR_P7_EN
                    state_d = DIV7;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef FACTOR_P7_EN
            DIV7: begin
                if (r_nz && m7 == '0) begin
                    r_d  = q7;
                    c7_d = (&c7_q) ? c7_q : c7_q + 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (i_out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new operand overrides everything, including a same-edge consume.
        if (accept) begin
            state_d = DIV2;
            r_d     = i_n;
            c2_d    = '0;
            c3_d    = '0;
            c5_d    = '0;
`ifdef FACTOR_P7_EN
            c7_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            c5_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            c5_q    <= c5_d;
        end
    end

`ifdef FACTOR_P7_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) c7_q <= '0;
        else        c7_q <= c7_d;
    end
    assign o_p7 = c7_q;
`else
    assign o_p7 = '0;
`endif

    assign o_out_valid = (state_q == DONE);
    assign o_p2        = c2_q;
    assign o_p3        = c3_q;
    assign o_p5        = c5_q;
    assign o_rem       = r_q;

    // Transistor count is a netlist property unknown at RTL; reported as zero.
    assign number = '0;

endmodule

// File: tb/tb_factor_seq_n.sv
// Directed scoreboard bench for factor_seq_n.
// Builds with or without FACTOR_P7_EN.
module tb_factor_seq_n;

`ifdef FACTOR_P7_EN
    localparam int  NP = 4;
    localparam bit  P7 = 1'b1;
`else
    localparam int  NP = 3;
    localparam bit  P7 = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic [15:0] i_n;
    logic        o_ready;
    logic        i_out_ready;
    logic        o_out_valid;
    logic [3:0]  o_p2;
    logic [3:0]  o_p3;
    logic [2:0]  o_p5;
    logic [2:0]  o_p7;
    logic [15:0] o_rem;
    logic [50:0] number;

    factor_seq_n dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_in_valid(i_in_valid),
        .i_n(i_n),
        .o_ready(o_ready),
        .i_out_ready(i_out_ready),
        .o_out_valid(o_out_valid),
        .o_p2(o_p2),
        .o_p3(o_p3),
        .o_p5(o_p5),
        .o_p7(o_p7),
        .o_rem(o_rem),
        .number(number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p2;
        int p3;
        int p5;
        int p7;
        int rem;
        int lat;
    } exp_t;

    exp_t sb[$];
    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int n);
        exp_t e;
        int r;
        r = n;
        e.p2 = 0; e.p3 = 0; e.p5 = 0; e.p7 = 0;
        while (r != 0 && r % 2 == 0) begin r /= 2; if (e.p2 < 15) e.p2++; end
        while (r != 0 && r % 3 == 0) begin r /= 3; if (e.p3 < 15) e.p3++; end
        while (r != 0 && r % 5 == 0) begin r /= 5; if (e.p5 < 7) e.p5++; end
        if (P7)
            while (r != 0 && r % 7 == 0) begin r /= 7; if (e.p7 < 7) e.p7++; end
        e.rem = r;
        e.lat = e.p2 + e.p3 + e.p5 + e.p7 + NP;
        return e;
    endfunction

    // Caller is between edges; returns at accept edge + 1.
    task automatic start(input logic [15:0] n, input exp_t e);
        chk("ready_before_accept", {31'd0, o_ready}, 1);
        i_in_valid = 1'b1;
        i_n        = n;
        sb.push_back(e);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        i_n        = 16'($urandom);
    endtask

    // Called at accept edge + 1; counts edges until the result appears.
    task automatic wait_result(input string tag);
        int   edges;
        exp_t e;
        edges = 0;
        while (o_out_valid !== 1'b1 && edges < 300) begin
            @(posedge clk);
            edges++;
            #1;
        end
        chk({tag, "_valid"}, {31'd0, o_out_valid}, 1);
        chk({tag, "_sb"}, (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_lat"}, edges, e.lat);
            chk({tag, "_p2"}, {28'd0, o_p2}, e.p2);
            chk({tag, "_p3"}, {28'd0, o_p3}, e.p3);
            chk({tag, "_p5"}, {29'd0, o_p5}, e.p5);
            chk({tag, "_p7"}, {29'd0, o_p7}, e.p7);
            chk({tag, "_rem"}, {16'd0, o_rem}, e.rem);
        end
    endtask

    task automatic consume(input string tag);
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        chk({tag, "_idle_valid"}, {31'd0, o_out_valid}, 0);
        chk({tag, "_idle_ready"}, {31'd0, o_ready}, 1);
    endtask

    exp_t e49;
    logic [15:0] rn;

    initial begin
        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_n         = '0;
        i_out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'd0, o_out_valid}, 0);
        chk("rst_ready", {31'd0, o_ready}, 1);
        chk("rst_p2", {28'd0, o_p2}, 0);
        chk("rst_p3", {28'd0, o_p3}, 0);
        chk("rst_p5", {29'd0, o_p5}, 0);
        chk("rst_p7", {29'd0, o_p7}, 0);
        chk("rst_rem", {16'd0, o_rem}, 0);
        #21;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start(16'd3600, '{p2:4, p3:2, p5:2, p7:0, rem:1, lat:11 + NP - 3});
        wait_result("n3600");
        consume("n3600");
        chk("hold_rem_after_consume", {16'd0, o_rem}, 1);
        chk("hold_p2_after_consume", {28'd0, o_p2}, 4);

        start(16'd0, '{p2:0, p3:0, p5:0, p7:0, rem:0, lat:NP});
        wait_result("n0");
        consume("n0");

        start(16'd65535, '{p2:0, p3:1, p5:1, p7:0, rem:4369, lat:2 + NP});
        // Busy: a new operand must be ignored.
        i_in_valid = 1'b1;
        i_n        = 16'd7;
        #1;
        chk("busy_ready", {31'd0, o_ready}, 0);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        chk("busy_valid", {31'd0, o_out_valid}, 0);
        // One edge already elapsed: account for it in the latency.
        sb[0].lat = sb[0].lat - 1;
        wait_result("n65535");
        consume("n65535");

        // Stall, then back-to-back consume + accept.
        start(16'd3600, '{p2:4, p3:2, p5:2, p7:0, rem:1, lat:11 + NP - 3});
        wait_result("b2b_first");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {31'd0, o_out_valid}, 1);
            chk("stall_rem", {16'd0, o_rem}, 1);
            chk("stall_p3", {28'd0, o_p3}, 2);
        end
        if (P7) e49 = '{p2:0, p3:0, p5:0, p7:2, rem:1, lat:2 + NP};
        else    e49 = '{p2:0, p3:0, p5:0, p7:0, rem:49, lat:NP};
        i_out_ready = 1'b1;
        i_in_valid  = 1'b1;
        i_n         = 16'd49;
        #1;
        chk("b2b_ready", {31'd0, o_ready}, 1);
        sb.push_back(e49);
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        i_in_valid  = 1'b0;
        chk("b2b_not_idle", {31'd0, o_ready}, 0);
        wait_result("n49");
        consume("n49");

        // Boundary / random operands against the model.
        start(16'd32768, model(32768));
        wait_result("n32768");
        consume("n32768");
        start(16'd16807, model(16807));
        wait_result("n16807");
        consume("n16807");
        start(16'd15625, model(15625));
        wait_result("n15625");
        consume("n15625");
        for (int i = 0; i < 4; i++) begin
            rn = 16'($urandom_range(1, 65535));
            start(rn, model(int'(rn)));
            wait_result("rand");
            consume("rand");
        end

        // Mid-operation reset.
        start(16'd1024, model(1024));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_valid", {31'd0, o_out_valid}, 0);
        chk("midrst_p2", {28'd0, o_p2}, 0);
        chk("midrst_rem", {16'd0, o_rem}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("postrst_ready", {31'd0, o_ready}, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_valid", {31'd0, o_out_valid}, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
